qedmma_fp_divider: RTL
======================

Name: qedmma_fp_divider

Overview:
- Sequential Q15.16 fixed-point divider. It is the inverse operation of the package multiply, and the hardware counterpart of the package combinational divide.
- Consumers are the tracker datapath blocks, for example Kalman gain, IMM normalisation and likelihood ratios. They need a/b on the 250 MHz clock without a 64-bit combinational divider.
- Radix-2 restoring division on magnitudes with a valid/ready handshake on both sides. Results are bit-exact to the package divide function, plus overflow and divide-by-zero flags.

Parameters:
- DATA_WIDTH, 32, operand and result width (Q15.16, signed two's complement).
- FRAC_BITS, 16, fractional bits.
- BITS_PER_CYCLE, 1, quotient bits resolved per clock. Legal values are 1, 2, 3, 4 (must divide DATA_WIDTH+FRAC_BITS).
- TAG_WIDTH, 3, opaque sideband passed from input to output (target index, MAX_TARGETS=8).

Ports:
- clk  in  1  system clock, 250 MHz.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider can accept operands.
- in_a  in  DATA_WIDTH  dividend, Q15.16 signed.
- in_b  in  DATA_WIDTH  divisor, Q15.16 signed.
- in_tag  in  TAG_WIDTH  sideband, captured on accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_q  out  DATA_WIDTH  quotient, Q15.16.
- out_tag  out  TAG_WIDTH  captured in_tag.
- out_ovf  out  1  true quotient not representable in signed DATA_WIDTH.
- out_dz  out  1  divisor was zero.

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_q=0, out_tag=0, out_ovf=0, out_dz=0, iteration counter 0.
- Arithmetic definition, with W=DATA_WIDTH and F=FRAC_BITS:
  - N = sign-extend(in_a) << F, a 48-bit signed value.
  - Q = N / in_b, truncated toward zero.
  - out_q = low W bits of Q in two's complement. This is identical to the package divide function.
- Magnitude datapath:
  - |N| is at most 2^47, held as 48-bit unsigned.
  - |b| is at most 2^31, held as 33-bit unsigned so that b = 0x8000_0000 is handled.
  - The partial remainder is 34 bits.
  - Quotient sign = sign(a) XOR sign(b), applied by two's-complement negation of the magnitude quotient in the final step.
  - A zero quotient is never negative.
- out_ovf = 1 when the magnitude quotient is greater than 2^(W-1)-1 for a positive result, or greater than 2^(W-1) for a negative result. out_q still carries the wrapped low W bits.
- Divide by zero (in_b == 0): out_q = 0x0001_0000 (FP_ONE), out_dz=1, out_ovf=0, and no iterations are run.
- State machine:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch operands and tag, then go to DONE if b==0, otherwise to CALC with the counter set to (W+F)/BITS_PER_CYCLE - 1.
  - CALC: in_ready=0. Each cycle shifts in BITS_PER_CYCLE dividend bits and resolves BITS_PER_CYCLE quotient bits MSB-first. When the counter reaches 0, apply the sign fixup, register out_q/out_ovf and go to DONE.
  - DONE: out_valid=1, and outputs are held stable while out_ready=0. On out_ready=1, go to IDLE and clear out_valid.
- Handshake and latency:
  - in_ready is asserted only in IDLE. in_valid is ignored in CALC and DONE. There is no back-to-back accept in DONE.
  - With the accept edge at cycle k, out_valid rises at cycle k+1+(W+F)/BITS_PER_CYCLE: k+49 for R=1, k+13 for R=4.
  - For a divide by zero, out_valid rises at k+1.
  - Throughput is one divide per (W+F)/R + 2 cycles when out_ready is held high.
- Outputs out_q, out_tag, out_ovf and out_dz change only on the CALC-to-DONE or IDLE-to-DONE transition.
- Reset asserted mid-CALC or mid-DONE immediately aborts the operation and forces all reset values. No partial result is ever presented.
- Any in_a is legal, including 0x8000_0000. in_a = 0 yields out_q = 0 with ovf=0, except when b==0, where dz applies.

Test Plan:
- a=0x0003_0000, b=0x0002_0000, R=1, accept at k -> out_valid at k+49, out_q=0x0001_8000, ovf=0, dz=0, tag echoed.
- a=0xFFFF_0000, b=0x0003_0000 -> out_q=0xFFFF_AAAB (truncation toward zero); a=0x0001_0000, b=0xFFFD_0000 -> 0xFFFF_AAAB.
- b=0, a=0x1234_5678 -> out_valid at k+1, out_q=0x0001_0000, dz=1, ovf=0.
- Overflow: a=0x7FFF_0000, b=0x0000_0001 -> out_q=0x0000_0000, ovf=1; a=0x8000_0000, b=0xFFFF_0000 -> out_q=0x8000_0000, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid with new operands -> outputs stable, in_ready=0, no new accept. Raise out_ready -> IDLE next cycle and in_ready=1.
- Reset pulse at k+20 of a CALC -> out_valid=0 and all outputs 0 immediately, in_ready=1 after release. Then run a randomized 10k-vector sweep at R=1 and R=4, checked against the package divide function plus the ovf/dz reference.

Source files
------------

// File: rtl/qedmma_fp_divider.sv
// Sequential Q15.16 fixed-point divider: radix-2^BITS_PER_CYCLE restoring division on magnitudes,
// valid/ready on both sides, with overflow and divide-by-zero flags.
module qedmma_fp_divider #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FRAC_BITS      = 16,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned TAG_WIDTH      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_q,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_ovf,
    output logic                  out_dz
);

    localparam int unsigned NW    = DATA_WIDTH + FRAC_BITS;
    localparam int unsigned STEPS = NW / BITS_PER_CYCLE;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0]         CNT_INIT = CW'(STEPS - 1);
    localparam logic [DATA_WIDTH-1:0] FP_ONE   = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;
    localparam logic [NW-1:0]         Q_LIM    = {{(NW-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [NW-1:0]         dvd, dvd_nxt, n_ext, n_mag;
    logic [DATA_WIDTH:0]   dvs, b_ext, b_mag;
    logic [DATA_WIDTH+1:0] rem, rem_nxt;
    logic [CW-1:0]         cnt;
    logic [TAG_WIDTH-1:0]  tag_r;
    logic                  neg, accept, b_zero, last, q_ovf;
    logic [DATA_WIDTH-1:0] q_low, q_fix;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign b_zero    = (in_b == '0);
    assign last      = (cnt == '0);

    // Divisor is widened by one bit so that |0x8000_0000| = 2^31 is representable.
    assign n_ext = {in_a, {FRAC_BITS{1'b0}}};
    assign n_mag = in_a[DATA_WIDTH-1] ? -n_ext : n_ext;
    assign b_ext = {in_b[DATA_WIDTH-1], in_b};
    assign b_mag = in_b[DATA_WIDTH-1] ? -b_ext : b_ext;

    // dvd shifts dividend bits out at the top and quotient bits in at the bottom.
    always_comb begin
        rem_nxt = rem;
        dvd_nxt = dvd;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_nxt = {rem_nxt[DATA_WIDTH:0], dvd_nxt[NW-1]};
            dvd_nxt = {dvd_nxt[NW-2:0], 1'b0};
            if (rem_nxt >= {1'b0, dvs}) begin
                rem_nxt    = rem_nxt - {1'b0, dvs};
                dvd_nxt[0] = 1'b1;
            end
        end
    end

    assign q_low = dvd_nxt[DATA_WIDTH-1:0];
    assign q_fix = neg ? -q_low : q_low;
    assign q_ovf = neg ? (dvd_nxt > Q_LIM) : (dvd_nxt >= Q_LIM);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = b_zero ? DONE : CALC;
            CALC:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            tag_r   <= '0;
            out_q   <= '0;
            out_tag <= '0;
            out_ovf <= 1'b0;
            out_dz  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    dvd   <= n_mag;
                    dvs   <= b_mag;
                    rem   <= '0;
                    cnt   <= CNT_INIT;
                    neg   <= in_a[DATA_WIDTH-1] ^ in_b[DATA_WIDTH-1];
                    tag_r <= in_tag;
                    if (b_zero) begin
                        out_q   <= FP_ONE;
                        out_ovf <= 1'b0;
                        out_dz  <= 1'b1;
                        out_tag <= in_tag;
                    end
                end
                CALC: begin
                    dvd <= dvd_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        out_q   <= q_fix;
                        out_ovf <= q_ovf;
                        out_dz  <= 1'b0;
                        out_tag <= tag_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
